vga_timing_gen: RTL and testbench

- Generates VGA 640x480@60 raster timing from the board clock.
- Produces the horizontal/vertical counter values consumed directly by the pixel-colour stage (display_M), plus hsync/vsync for the connector.
- Divides the system clock down to a pixel-rate enable and advances the raster once per pixel tick.
- All outputs are registered and mutually aligned.

---
 rtl/vga_timing_gen_if.sv | 19 +
 rtl/vga_timing_gen.sv | 87 ++++++++
 tb/tb_vga_timing_gen.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the VGA timing generator to the colour stage and connector.
// The generator drives everything; consumers sample the counters every clk.
interface vga_timing_gen_if;
  logic [15:0] H_Counter_Value;
  logic [15:0] V_Counter_Value;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic        pix_tick;
  logic        frame_start;

  modport master (
    output H_Counter_Value, V_Counter_Value, hsync, vsync, video_on, pix_tick, frame_start
  );

  modport slave (
    input H_Counter_Value, V_Counter_Value, hsync, vsync, video_on, pix_tick, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: clock divider to pixel rate, H/V counters, and sync/visible flags
// registered from next-state counters so every output lines up with the counters.
module vga_timing_gen #(
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_VIS_START = 144,
  parameter int H_VIS_END   = 784,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_VIS_START = 35,
  parameter int V_VIS_END   = 515
) (
  input  logic              clk,
  input  logic              reset,
  vga_timing_gen_if.master  vga
);

  localparam logic [4:0]  DIV_LAST = 5'(CLK_DIV - 1);
  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);

  logic [4:0]  div_reg, div_next;
  logic [15:0] h_reg, h_next;
  logic [15:0] v_reg, v_next;
  logic        hsync_reg, hsync_next;
  logic        vsync_reg, vsync_next;
  logic        video_on_reg, video_on_next;
  logic        pix_tick_reg;
  logic        frame_start_reg, frame_start_next;
  logic        advance;

  always_comb begin
    advance          = (div_reg == DIV_LAST);
    div_next         = advance ? 5'd0 : div_reg + 5'd1;
    h_next           = h_reg;
    v_next           = v_reg;
    frame_start_next = 1'b0;

    if (advance) begin
      if (h_reg == H_LAST) begin
        h_next = 16'd0;
        v_next = (v_reg == V_LAST) ? 16'd0 : v_reg + 16'd1;
      end else begin
        h_next = h_reg + 16'd1;
      end
      frame_start_next = (h_next == 16'd0) && (v_next == 16'd0);
    end

    // Flags are derived from the values the counters are about to take.
    hsync_next    = (h_next >= 16'(H_SYNC));
    vsync_next    = (v_next >= 16'(V_SYNC));
    video_on_next = (h_next >= 16'(H_VIS_START)) && (h_next < 16'(H_VIS_END)) &&
                    (v_next >= 16'(V_VIS_START)) && (v_next < 16'(V_VIS_END));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg         <= 5'd0;
      h_reg           <= 16'd0;
      v_reg           <= 16'd0;
      hsync_reg       <= 1'b0;
      vsync_reg       <= 1'b0;
      video_on_reg    <= 1'b0;
      pix_tick_reg    <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      div_reg         <= div_next;
      h_reg           <= h_next;
      v_reg           <= v_next;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      video_on_reg    <= video_on_next;
      pix_tick_reg    <= advance;
      frame_start_reg <= frame_start_next;
    end
  end

  assign vga.H_Counter_Value = h_reg;
  assign vga.V_Counter_Value = v_reg;
  assign vga.hsync           = hsync_reg;
  assign vga.vsync           = vsync_reg;
  assign vga.video_on        = video_on_reg;
  assign vga.pix_tick        = pix_tick_reg;
  assign vga.frame_start     = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-timing instance plus a shrunken-raster instance,
// both compared every clk against an arithmetic model indexed by clocks since reset.
module tb_vga_timing_gen;

  // Shrunken raster so whole frames fit in a short run.
  localparam int S_DIV = 3, S_HT = 20, S_HS = 3, S_HVS = 5, S_HVE = 17;
  localparam int S_VT  = 12, S_VS = 2, S_VVS = 4, S_VVE = 10;

  logic clk = 1'b0;
  logic reset_def = 1'b1;
  logic reset_sml = 1'b1;
  int   n_def = 0;
  int   n_sml = 0;
  bit   chk_on = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  vga_timing_gen_if vif_def ();
  vga_timing_gen_if vif_sml ();

  vga_timing_gen dut_def (.clk(clk), .reset(reset_def), .vga(vif_def));

  vga_timing_gen #(
    .CLK_DIV(S_DIV), .H_TOTAL(S_HT), .H_SYNC(S_HS), .H_VIS_START(S_HVS), .H_VIS_END(S_HVE),
    .V_TOTAL(S_VT), .V_SYNC(S_VS), .V_VIS_START(S_VVS), .V_VIS_END(S_VVE)
  ) dut_sml (.clk(clk), .reset(reset_sml), .vga(vif_sml));

  always #5 clk = ~clk;

  // Clocks elapsed since the last reset edge (0 while reset is held).
  always @(posedge clk) begin
    n_def <= reset_def ? 0 : n_def + 1;
    n_sml <= reset_sml ? 0 : n_sml + 1;
  end

  // Expected {H, V, hsync, vsync, video_on, pix_tick, frame_start} after n clocks.
  function automatic logic [36:0] model(input int n, input int cdiv, input int ht, input int hs_w,
                                        input int hvs, input int hve, input int vt, input int vs_w,
                                        input int vvs, input int vve);
    int p, h, v;
    logic pt, fs, hs, vs, vo;
    pt = (n > 0) && ((n % cdiv) == 0);
    p  = (n / cdiv) % (ht * vt);
    h  = p % ht;
    v  = p / ht;
    fs = pt && (p == 0);
    hs = (h >= hs_w);
    vs = (v >= vs_w);
    vo = (h >= hvs) && (h < hve) && (v >= vvs) && (v < vve);
    return {16'(h), 16'(v), hs, vs, vo, pt, fs};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [36:0] pack(input logic [15:0] h, input logic [15:0] v, input logic hs,
                                       input logic vs, input logic vo, input logic pt, input logic fs);
    return {h, v, hs, vs, vo, pt, fs};
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_def",
            64'(pack(vif_def.H_Counter_Value, vif_def.V_Counter_Value, vif_def.hsync, vif_def.vsync,
                     vif_def.video_on, vif_def.pix_tick, vif_def.frame_start)),
            64'(model(n_def, 4, 800, 96, 144, 784, 525, 2, 35, 515)));
      check("model_sml",
            64'(pack(vif_sml.H_Counter_Value, vif_sml.V_Counter_Value, vif_sml.hsync, vif_sml.vsync,
                     vif_sml.video_on, vif_sml.pix_tick, vif_sml.frame_start)),
            64'(model(n_sml, S_DIV, S_HT, S_HS, S_HVS, S_HVE, S_VT, S_VS, S_VVS, S_VVE)));
    end
  end

  typedef struct {
    int   h;
    int   v;
    logic vo;
    logic hs;
    logic vs;
  } vec_t;

  vec_t vecs[10];

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic pulse_reset_sml();
    reset_sml = 1'b1;
    tick(1);
    reset_sml = 1'b0;
  endtask

  initial begin
    int cnt, n0, n1, off;

    vecs[0] = '{4, 4, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{5, 4, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{16, 9, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{17, 9, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{5, 3, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{5, 10, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{2, 0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{3, 1, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{0, 2, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{19, 11, 1'b0, 1'b1, 1'b1};

    // Reset held 3 clks on both instances.
    tick(1);
    chk_on = 1'b1;
    tick(2);
    reset_def = 1'b0;
    reset_sml = 1'b0;
    check("rst_h", 64'(vif_def.H_Counter_Value), 64'd0);
    check("rst_v", 64'(vif_def.V_Counter_Value), 64'd0);
    check("rst_flags", 64'({vif_def.hsync, vif_def.vsync, vif_def.video_on, vif_def.pix_tick,
                            vif_def.frame_start}), 64'd0);

    // First pix_tick arrives 4 clks after release, with H=1.
    cnt = 0;
    while (vif_def.pix_tick !== 1'b1 && cnt < 20) begin
      tick(1);
      cnt++;
    end
    check("first_tick_lat", 64'(cnt), 64'd4);
    check("first_tick_h", 64'(vif_def.H_Counter_Value), 64'd1);

    // Visible-window and sync boundaries on the small raster.
    for (int i = 0; i < 10; i++) begin
      pulse_reset_sml();
      tick((vecs[i].v * S_HT + vecs[i].h) * S_DIV);
      $display("vec %0d: H=%0d V=%0d vo=%0b hs=%0b vs=%0b", i, vif_sml.H_Counter_Value,
               vif_sml.V_Counter_Value, vif_sml.video_on, vif_sml.hsync, vif_sml.vsync);
      check("vec_hv", 64'({vif_sml.H_Counter_Value, vif_sml.V_Counter_Value}),
            64'({16'(vecs[i].h), 16'(vecs[i].v)}));
      check("vec_flags", 64'({vif_sml.video_on, vif_sml.hsync, vif_sml.vsync}),
            64'({vecs[i].vo, vecs[i].hs, vecs[i].vs}));
    end

    // Frame wrap and frame period on the small raster.
    pulse_reset_sml();
    tick((S_HT * S_VT - 1) * S_DIV);
    tick(S_DIV);
    check("fwrap_hv", 64'({vif_sml.H_Counter_Value, vif_sml.V_Counter_Value}), 64'd0);
    check("fwrap_fs", 64'({vif_sml.frame_start, vif_sml.pix_tick, vif_sml.vsync}), 64'b110);
    n0 = n_sml;
    tick(1);
    check("fwrap_fs_width", 64'(vif_sml.frame_start), 64'd0);
    cnt = 0;
    while (vif_sml.frame_start !== 1'b1 && cnt < 2000) begin
      tick(1);
      cnt++;
    end
    n1 = n_sml;
    $display("frame period: %0d clks", n1 - n0);
    check("frame_period", 64'(n1 - n0), 64'(S_DIV * S_HT * S_VT));

    // Random mid-frame, mid-divide resets; the continuous model also covers the restart.
    for (int i = 0; i < 20; i++) begin
      off = int'($urandom_range(1, 1500));
      tick(off);
      reset_sml = 1'b1;
      tick(1);
      $display("rand reset %0d after %0d clks: H=%0d V=%0d fs=%0b", i, off,
               vif_sml.H_Counter_Value, vif_sml.V_Counter_Value, vif_sml.frame_start);
      check("rrst_hv", 64'({vif_sml.H_Counter_Value, vif_sml.V_Counter_Value}), 64'd0);
      check("rrst_flags", 64'({vif_sml.hsync, vif_sml.vsync, vif_sml.video_on, vif_sml.pix_tick,
                               vif_sml.frame_start}), 64'd0);
      tick(int'($urandom_range(0, 2)));
      reset_sml = 1'b0;
    end

    // Line wrap at default timing: (799,10) -> (0,11), then hsync low width.
    reset_def = 1'b1;
    tick(1);
    reset_def = 1'b0;
    tick((10 * 800 + 799) * 4);
    check("lwrap_pre", 64'({vif_def.H_Counter_Value, vif_def.V_Counter_Value}),
          64'({16'd799, 16'd10}));
    tick(4);
    check("lwrap_post", 64'({vif_def.H_Counter_Value, vif_def.V_Counter_Value, vif_def.hsync}),
          64'({16'd0, 16'd11, 1'b0}));
    cnt = 0;
    while (vif_def.hsync === 1'b0 && cnt < 1000) begin
      cnt++;
      tick(1);
    end
    $display("hsync low width: %0d clks, rise at H=%0d", cnt, vif_def.H_Counter_Value);
    check("hsync_width", 64'(cnt), 64'd384);
    check("hsync_rise_h", 64'(vif_def.H_Counter_Value), 64'd96);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
